// File: rtl/paddle_if.sv
// Paddle control bundle: encoder/auto inputs toward the paddle, bitmap and position back out.
interface paddle_if;
  logic        enc_a;
  logic        enc_b;
  logic        auto_mode;
  logic [3:0]  ball_y;
  logic [15:0] paddle;
  logic [3:0]  pos;
  logic        moved;

  modport master (
    output enc_a, enc_b, auto_mode, ball_y,
    input  paddle, pos, moved
  );

  modport slave (
    input  enc_a, enc_b, auto_mode, ball_y,
    output paddle, pos, moved
  );
endinterface

// File: rtl/paddle.sv
// Paddle position controller: debounced quadrature encoder in manual mode,
// ball-tracking divider in auto mode; registered occupancy bitmap output.
module paddle #(
    parameter int PADDLE_LEN = 3,
    parameter int DEBOUNCE   = 4,
    parameter int AUTO_DIV   = 100
) (
    input logic   clk,
    input logic   reset_n,
    paddle_if.slave bus
);

    localparam int          MAX_POS   = 16 - PADDLE_LEN;
    localparam int          HALF      = PADDLE_LEN / 2;
    localparam logic [3:0]  MAX_POS4  = 4'(MAX_POS);
    localparam logic [3:0]  RESET_POS = 4'((16 - PADDLE_LEN) / 2);
    localparam logic [15:0] MASK      = 16'((1 << PADDLE_LEN) - 1);
    localparam int          DIV_W     = $clog2(AUTO_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic              a_meta, a_sync, b_meta, b_sync;
    logic [1:0]        ab_sync;
    logic              loaded;
    logic [1:0]        db_ab, cand;
    logic [7:0]        db_cnt, cnt_next;
    logic              accept;
    logic signed [1:0] step_dec, step;
    logic signed [3:0] acc, acc_sum, acc_next;
    logic [DIV_W-1:0]  div, div_next;
    logic [3:0]        pos_q, pos_next, target;
    logic [15:0]       paddle_q;
    logic              moved_q;
    int                tgt;

    assign ab_sync = {a_sync, b_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= bus.enc_a;
            a_sync <= a_meta;
            b_meta <= bus.enc_b;
            b_sync <= b_meta;
        end
    end

    always_comb begin
        cnt_next = (ab_sync == cand) ? db_cnt + 8'd1 : 8'd1;
        accept   = loaded && (ab_sync != db_ab) && (cnt_next >= 8'(DEBOUNCE));
        case ({db_ab, ab_sync})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step_dec = 2'sd1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: step_dec = -2'sd1;
            default:                            step_dec = 2'sd0;
        endcase
    end

    // The decoded step is registered with the debounced state, giving one
    // cycle of latency between acceptance and the position update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loaded <= 1'b0;
            db_ab  <= '0;
            cand   <= '0;
            db_cnt <= '0;
            step   <= '0;
        end else begin
            step <= '0;
            cand <= ab_sync;
            if (!loaded) begin
                loaded <= 1'b1;
                db_ab  <= ab_sync;
                db_cnt <= '0;
            end else if (ab_sync == db_ab) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_ab  <= ab_sync;
                db_cnt <= '0;
                step   <= step_dec;
            end else begin
                db_cnt <= cnt_next;
            end
        end
    end

    always_comb begin
        tgt = int'(bus.ball_y) - HALF;
        if (tgt < 0)
            tgt = 0;
        else if (tgt > MAX_POS)
            tgt = MAX_POS;
        target = 4'(tgt);
    end

    always_comb begin
        pos_next = pos_q;
        acc_next = acc;
        div_next = div;
        acc_sum  = acc + $signed({{2{step[1]}}, step});
        if (bus.auto_mode) begin
            acc_next = '0;
            if (div == DIV_LAST) begin
                div_next = '0;
                if (pos_q < target)
                    pos_next = pos_q + 4'd1;
                else if (pos_q > target)
                    pos_next = pos_q - 4'd1;
            end else begin
                div_next = div + DIV_W'(1);
            end
        end else begin
            div_next = '0;
            if (acc_sum == 4'sd4) begin
                acc_next = '0;
                if (pos_q < MAX_POS4)
                    pos_next = pos_q + 4'd1;
            end else if (acc_sum == -4'sd4) begin
                acc_next = '0;
                if (pos_q != 4'd0)
                    pos_next = pos_q - 4'd1;
            end else begin
                acc_next = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q    <= RESET_POS;
            paddle_q <= MASK << RESET_POS;
            moved_q  <= 1'b0;
            acc      <= '0;
            div      <= '0;
        end else begin
            pos_q    <= pos_next;
            paddle_q <= MASK << pos_next;
            moved_q  <= (pos_next != pos_q);
            acc      <= acc_next;
            div      <= div_next;
        end
    end

    assign bus.pos    = pos_q;
    assign bus.paddle = paddle_q;
    assign bus.moved  = moved_q;

endmodule

// File: tb/tb_paddle.sv
// Scoreboard bench for paddle: expected moves queued by stimulus, popped by a
// monitor on every moved pulse; direct checks cover reset and boundaries.
module tb_paddle;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    paddle_if bus();

    paddle #(.PADDLE_LEN(3), .DEBOUNCE(4), .AUTO_DIV(100)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0]  pos;
        logic [15:0] paddle;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   moves      = 0;
    int   mpos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.moved === 1'b1) begin
            exp_t e;
            moves++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_move: got pos %0d, required no move", bus.pos);
            end else begin
                e = exp_q.pop_front();
                check("move_pos", 32'(bus.pos), 32'(e.pos));
                check("move_paddle", 32'(bus.paddle), 32'(e.paddle));
            end
        end
    end

    task automatic hold_ab(input logic [1:0] ab, input int n);
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cw_detent();
        hold_ab(2'b01, 10);
        hold_ab(2'b11, 10);
        hold_ab(2'b10, 10);
        hold_ab(2'b00, 10);
    endtask

    task automatic ccw_detent();
        hold_ab(2'b10, 10);
        hold_ab(2'b11, 10);
        hold_ab(2'b01, 10);
        hold_ab(2'b00, 10);
    endtask

    task automatic push_move(input int p);
        exp_t e;
        e.pos    = 4'(p);
        e.paddle = 16'h0007 << p;
        exp_q.push_back(e);
    endtask

    task automatic model_cw();
        if (mpos < 13) begin
            mpos++;
            push_move(mpos);
        end
        cw_detent();
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.enc_a     = 1'b0;
        bus.enc_b     = 1'b0;
        bus.auto_mode = 1'b0;
        bus.ball_y    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pos", 32'(bus.pos), 32'd6);
        check("reset_paddle", 32'(bus.paddle), 32'h01C0);
        check("reset_moved", 32'(bus.moved), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("release_pos", 32'(bus.pos), 32'd6);
        mpos = 6;
    endtask

    initial begin
        int m0;
        do_reset();

        // single clockwise detent
        m0 = moves;
        model_cw();
        check("cw_pos", 32'(bus.pos), 32'd7);
        check("cw_paddle", 32'(bus.paddle), 32'h0380);
        check("cw_pulses", 32'(moves - m0), 32'd1);

        // short glitch must be rejected
        hold_ab(2'b01, 2);
        hold_ab(2'b00, 20);
        check("glitch_pos", 32'(bus.pos), 32'd7);

        // counter-clockwise detent
        mpos = 6;
        push_move(6);
        ccw_detent();
        check("ccw_pos", 32'(bus.pos), 32'd6);
        check("ccw_paddle", 32'(bus.paddle), 32'h01C0);

        // two-bit jumps count no steps
        hold_ab(2'b11, 10);
        hold_ab(2'b00, 10);
        hold_ab(2'b11, 10);
        hold_ab(2'b00, 10);
        check("illegal_pos", 32'(bus.pos), 32'd6);

        // saturation at the top bound
        do_reset();
        m0 = moves;
        for (int i = 0; i < 10; i++) model_cw();
        check("sat_pos", 32'(bus.pos), 32'd13);
        check("sat_paddle", 32'(bus.paddle), 32'hE000);
        check("sat_pulses", 32'(moves - m0), 32'd7);
        check("sat_queue", 32'(exp_q.size()), 32'd0);

        // reset mid-detent clears partial accumulation
        hold_ab(2'b01, 10);
        hold_ab(2'b11, 10);
        reset_n = 1'b0;
        #1;
        check("midrst_pos", 32'(bus.pos), 32'd6);
        check("midrst_paddle", 32'(bus.paddle), 32'h01C0);
        check("midrst_moved", 32'(bus.moved), 32'd0);
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push_move(7);
        hold_ab(2'b01, 10);
        hold_ab(2'b11, 10);
        check("midrst_partial_pos", 32'(bus.pos), 32'd6);
        hold_ab(2'b10, 10);
        hold_ab(2'b00, 10);
        check("midrst_detent_pos", 32'(bus.pos), 32'd7);

        // auto mode tracks ball_y=0 with encoder noise ignored
        do_reset();
        for (int p = 5; p >= 0; p--) push_move(p);
        m0 = moves;
        bus.auto_mode = 1'b1;
        fork
            begin
                repeat (10) cw_detent();
            end
        join_none
        for (int k = 1; k <= 6; k++) begin
            repeat (99) @(posedge clk);
            #1;
            check("auto_before_move", 32'(bus.pos), 32'(7 - k));
            @(posedge clk);
            #1;
            check("auto_after_move", 32'(bus.pos), 32'(6 - k));
        end
        repeat (150) @(posedge clk);
        #1;
        check("auto_hold_pos", 32'(bus.pos), 32'd0);
        check("auto_hold_paddle", 32'(bus.paddle), 32'h0007);
        check("auto_pulses", 32'(moves - m0), 32'd6);
        bus.auto_mode = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
